pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning: maximum cycles spent in MEM without dmem_ack before trapping (legal range 1..255).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high, highest priority.
REQ-005 imem_valid  in  1  instruction word valid on imem bus this cycle.
REQ-006 opcode  in  6  instr[31:26] from imem bus, sampled only when ir_we=1.
REQ-007 funct  in  6  instr[5:0] from imem bus, sampled only when ir_we=1.
REQ-008 dmem_ack  in  1  data memory completion, single-cycle pulse.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 ir_we  out  1  instruction register write strobe.
REQ-011 dmem_re  out  1  data read request (lw).
REQ-012 dmem_we  out  1  data write request (sw).
REQ-013 reg_we  out  1  register file write strobe.
REQ-014 pc_we  out  1  PC register write strobe; PC loads PC_Calc new_PC.
REQ-015 PCSel  out  2  PC_Calc select: 00 jump target, 01 added_PC, 10 Da (jr), 11 zero.
REQ-016 AddSel  out  1  PC_Calc adder select: 0 PC+4, 1 branch offset path.
REQ-017 trap  out  1  sticky fault indicator.
REQ-018 state  out  3  current state encoding (debug).

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, TRAP=4; codes 5-7 SHALL transition to TRAP.
REQ-020 Defaults in every state unless overridden: all strobes 0, PCSel=01, AddSel=0, trap=0.
REQ-021 FETCH: imem_req=1; ir_we=imem_valid (same cycle, combinational); when imem_valid=1, latch opcode/funct internally and go to DECODE, else remain.
REQ-022 DECODE: one cycle, no strobes; lw(100011)/sw(101011) -> MEM; R-type(000000) with funct add(100000)/sub(100010)/slt(101010)/jr(001000), j(000010), jal(000011), bne(000101), addi(001000), xori(001110) -> EXEC; anything else -> TRAP.
REQ-023 EXEC: one cycle, pc_we=1, next FETCH; outputs by latched instruction:
- add/sub/slt/addi/xori: reg_we=1, PCSel=01, AddSel=0.
- bne: reg_we=0, PCSel=01, AddSel=1 (taken/not-taken resolved in datapath by isZero).
- j: reg_we=0, PCSel=00.
- jal: reg_we=1 (link), PCSel=00.
- jr: reg_we=0, PCSel=10.
REQ-024 MEM: dmem_re=1 (lw) or dmem_we=1 (sw) held every cycle until dmem_ack; 8-bit wait counter cleared on MEM entry, increments each MEM cycle without ack.
REQ-025 MEM ack cycle: pc_we=1, PCSel=01, AddSel=0, reg_we=1 only for lw; next FETCH.
REQ-026 MEM timeout: counter reaching MEM_TIMEOUT with dmem_ack=0 -> TRAP next cycle; ack on that same cycle takes priority (normal completion).
REQ-027 TRAP: trap=1, pc_we=1, PCSel=11 every cycle (PC held at 0); all other strobes 0; exits only on reset.
REQ-028 Latency: ALU/jump/branch instruction = 3 cycles from imem_valid cycle to next imem_req (FETCH, DECODE, EXEC); lw/sw = 3 + wait cycles.
REQ-029 dmem_ack outside MEM and imem_valid outside FETCH SHALL be ignored.
REQ-030 pc_we SHALL assert at most once per retired instruction (outside TRAP).

Reset
REQ-031 reset=1 at a clock edge: state<=FETCH, wait counter<=0, latched opcode/funct<=0; takes priority over all transitions including MEM ack and TRAP.
REQ-032 While reset=1 all outputs SHALL be driven to defaults (strobes 0, PCSel=01, AddSel=0, trap=0, imem_req=0), regardless of state.
REQ-033 Reset mid-MEM aborts the access: dmem_re/dmem_we SHALL be 0 in the reset cycle and after; no pc_we/reg_we for the aborted instruction.

Verification
REQ-034 Reset 2 cycles, release, imem_valid=0 -> state=0, imem_req=1, all other strobes 0, trap=0 for 10 cycles.
REQ-035 add (opcode 0x00, funct 0x20) with imem_valid cycle N -> ir_we=1 at N, state=1 at N+1, at N+2 reg_we=1 pc_we=1 PCSel=01 AddSel=0, imem_req=1 at N+3.
REQ-036 bne (0x05), then jr (0x00/0x08) -> EXEC cycles show pc_we=1 AddSel=1 PCSel=01 reg_we=0, then pc_we=1 PCSel=10 reg_we=0.
REQ-037 lw (0x23), dmem_ack 3 cycles after MEM entry -> dmem_re=1 for 4 cycles, ack cycle reg_we=1 pc_we=1, FETCH next.
REQ-038 sw (0x2B), MEM_TIMEOUT=15, no ack -> dmem_we=1 for 15 cycles, then state=4, trap=1, pc_we=1, PCSel=11 held until reset; reset -> FETCH, trap=0.
REQ-039 Illegal opcode 0x3F -> TRAP right after DECODE with no reg_we; separately reset asserted in MEM cycle 2 -> dmem_re=0 immediately, state=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/TRAP. It drives the fetch, IR, data-memory,
// register-file and PC strobes and the PC_Calc select lines. A stalled data access ends in a sticky trap.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_re,
    output logic       dmem_we,
    output logic       reg_we,
    output logic       pc_we,
    output logic [1:0] PCSel,
    output logic       AddSel,
    output logic       trap,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur;
    logic [7:0] wait_cnt;
    logic [5:0] op_q;
    logic [5:0] fn_q;

    // Decode always works from the latched instruction; the imem bus is only trusted in FETCH.
    logic is_rtype, is_alu_r, is_jr, is_j, is_jal, is_bne, is_alu_i, is_lw, is_sw;
    logic is_exec_legal;

    always_comb begin
        is_rtype      = (op_q == OP_RTYPE);
        is_alu_r      = is_rtype && (fn_q == FN_ADD || fn_q == FN_SUB || fn_q == FN_SLT);
        is_jr         = is_rtype && (fn_q == FN_JR);
        is_j          = (op_q == OP_J);
        is_jal        = (op_q == OP_JAL);
        is_bne        = (op_q == OP_BNE);
        is_alu_i      = (op_q == OP_ADDI) || (op_q == OP_XORI);
        is_lw         = (op_q == OP_LW);
        is_sw         = (op_q == OP_SW);
        is_exec_legal = is_alu_r || is_jr || is_j || is_jal || is_bne || is_alu_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
            fn_q     <= '0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (imem_valid) begin
                        op_q <= opcode;
                        fn_q <= funct;
                        cur  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_lw || is_sw) begin
                        wait_cnt <= '0;
                        cur      <= S_MEM;
                    end else if (is_exec_legal) begin
                        cur <= S_EXEC;
                    end else begin
                        cur <= S_TRAP;
                    end
                end
                S_EXEC: cur <= S_FETCH;
                S_MEM: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (dmem_ack)                   cur      <= S_FETCH;
                    else if (wait_cnt == WAIT_LAST) cur      <= S_TRAP;
                    else                            wait_cnt <= wait_cnt + 8'd1;
                end
                S_TRAP:  cur <= S_TRAP;
                default: cur <= S_TRAP;
            endcase
        end
    end

    // Strobes are decoded from state plus live inputs.
    // ir_we follows imem_valid in FETCH, pc_we follows the ack in MEM, and reset forces the defaults.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        PCSel    = 2'b01;
        AddSel   = 1'b0;
        trap     = 1'b0;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_valid;
                end
                S_EXEC: begin
                    pc_we = 1'b1;
                    if (is_alu_r || is_alu_i) begin
                        reg_we = 1'b1;
                    end else if (is_bne) begin
                        AddSel = 1'b1;
                    end else if (is_j) begin
                        PCSel = 2'b00;
                    end else if (is_jal) begin
                        reg_we = 1'b1;
                        PCSel  = 2'b00;
                    end else if (is_jr) begin
                        PCSel = 2'b10;
                    end
                end
                S_MEM: begin
                    dmem_re = is_lw;
                    dmem_we = is_sw;
                    if (dmem_ack) begin
                        pc_we  = 1'b1;
                        reg_we = is_lw;
                    end
                end
                S_TRAP: begin
                    trap  = 1'b1;
                    pc_we = 1'b1;
                    PCSel = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table for instruction flows, reset and trap,
// plus hand sequences for the MEM wait/timeout boundaries.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, ir_we, dmem_re, dmem_we, reg_we, pc_we, AddSel, trap;
    logic [1:0] PCSel;
    logic [2:0] state;

    int nchk = 0;
    int nerr = 0;

    pc_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .imem_valid(imem_valid), .opcode(opcode), .funct(funct),
        .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .reg_we(reg_we), .pc_we(pc_we), .PCSel(PCSel), .AddSel(AddSel),
        .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // {imem_req, ir_we, dmem_re, dmem_we, reg_we, pc_we, PCSel, AddSel, trap, state}
    wire [12:0] obs = {imem_req, ir_we, dmem_re, dmem_we, reg_we, pc_we, PCSel, AddSel, trap, state};

    function automatic logic [12:0] E(input logic irq, irw, re, we, rwe, pcw,
                                      input logic [1:0] pcs, input logic as, tr,
                                      input logic [2:0] st);
        return {irq, irw, re, we, rwe, pcw, pcs, as, tr, st};
    endfunction

    typedef struct {
        string      name;
        logic       r;
        logic       iv;
        logic [5:0] op;
        logic [5:0] fn;
        logic       ack;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input string name, input logic r, iv, input logic [5:0] op, fn,
                       input logic ack, input logic [12:0] exp);
        vec_t v;
        v.name = name; v.r = r; v.iv = iv; v.op = op; v.fn = fn; v.ack = ack; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic drive(input logic r, iv, input logic [5:0] op, fn, input logic ack);
        @(posedge clk);
        #2;
        reset = r; imem_valid = iv; opcode = op; funct = fn; dmem_ack = ack;
        #1;
    endtask

    task automatic chk(input string name, input logic [12:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, obs, exp, $time);
        end
    endtask

    logic [12:0] RST0, F_IDLE, F_IR, DEC, EX_ALU, EX_BNE, EX_J, EX_JAL, EX_JR, TRP, RST4;

    initial begin
        RST0   = E(0,0,0,0,0,0,2'b01,0,0,3'd0);
        F_IDLE = E(1,0,0,0,0,0,2'b01,0,0,3'd0);
        F_IR   = E(1,1,0,0,0,0,2'b01,0,0,3'd0);
        DEC    = E(0,0,0,0,0,0,2'b01,0,0,3'd1);
        EX_ALU = E(0,0,0,0,1,1,2'b01,0,0,3'd2);
        EX_BNE = E(0,0,0,0,0,1,2'b01,1,0,3'd2);
        EX_J   = E(0,0,0,0,0,1,2'b00,0,0,3'd2);
        EX_JAL = E(0,0,0,0,1,1,2'b00,0,0,3'd2);
        EX_JR  = E(0,0,0,0,0,1,2'b10,0,0,3'd2);
        TRP    = E(0,0,0,0,0,1,2'b11,0,1,3'd4);
        RST4   = E(0,0,0,0,0,0,2'b01,0,0,3'd4);

        // Instruction flows, each a FETCH/DECODE/EXEC triple starting from FETCH.
        row("add_fetch",   0,1,6'h00,6'h20,0,F_IR);   row("add_dec",  0,0,0,0,0,DEC);
        row("add_exec",    0,0,0,0,0,EX_ALU);
        row("bne_fetch",   0,1,6'h05,6'h00,0,F_IR);   row("bne_dec",  0,0,0,0,0,DEC);
        row("bne_exec",    0,0,0,0,0,EX_BNE);
        row("jr_fetch",    0,1,6'h00,6'h08,0,F_IR);   row("jr_dec",   0,0,0,0,0,DEC);
        row("jr_exec",     0,0,0,0,0,EX_JR);
        row("jal_fetch",   0,1,6'h03,6'h00,0,F_IR);
        row("jal_dec_iv",  0,1,6'h3F,6'h3F,0,DEC);     // stray imem_valid must not reload IR
        row("jal_exec_ack",0,0,0,0,1,EX_JAL);          // stray dmem_ack ignored
        row("j_fetch",     0,1,6'h02,6'h00,0,F_IR);   row("j_dec",    0,0,0,0,0,DEC);
        row("j_exec",      0,0,0,0,0,EX_J);
        row("addi_fetch",  0,1,6'h08,6'h3F,0,F_IR);   row("addi_dec", 0,0,0,0,0,DEC);
        row("addi_exec",   0,0,0,0,0,EX_ALU);
        row("xori_fetch",  0,1,6'h0E,6'h00,0,F_IR);   row("xori_dec", 0,0,0,0,0,DEC);
        row("xori_exec",   0,0,0,0,0,EX_ALU);
        row("sub_fetch",   0,1,6'h00,6'h22,0,F_IR);   row("sub_dec",  0,0,0,0,0,DEC);
        row("sub_exec",    0,0,0,0,0,EX_ALU);
        row("slt_fetch",   0,1,6'h00,6'h2A,0,F_IR);   row("slt_dec",  0,0,0,0,0,DEC);
        row("slt_exec",    0,0,0,0,0,EX_ALU);
        row("idle_wait",   0,0,0,0,0,F_IDLE);
        // lw with ack three cycles after MEM entry
        row("lw_fetch",    0,1,6'h23,6'h00,0,F_IR);   row("lw_dec",   0,0,0,0,0,DEC);
        row("lw_mem1",     0,0,0,0,0,E(0,0,1,0,0,0,2'b01,0,0,3'd3));
        row("lw_mem2",     0,0,0,0,0,E(0,0,1,0,0,0,2'b01,0,0,3'd3));
        row("lw_mem3",     0,0,0,0,0,E(0,0,1,0,0,0,2'b01,0,0,3'd3));
        row("lw_mem_ack",  0,0,0,0,1,E(0,0,1,0,1,1,2'b01,0,0,3'd3));
        row("lw_refetch",  0,0,0,0,0,F_IDLE);
        // sw acked on its first MEM cycle
        row("sw_fetch",    0,1,6'h2B,6'h00,0,F_IR);   row("sw_dec",   0,0,0,0,0,DEC);
        row("sw_mem_ack",  0,0,0,0,1,E(0,0,0,1,0,1,2'b01,0,0,3'd3));
        row("sw_refetch",  0,0,0,0,0,F_IDLE);
        row("rst_fetch_iv",1,1,6'h00,6'h20,0,RST0);
        row("post_rst",    0,0,0,0,0,F_IDLE);
        // illegal opcode, trap is sticky until reset
        row("ill_fetch",   0,1,6'h3F,6'h00,0,F_IR);   row("ill_dec",  0,0,0,0,0,DEC);
        row("ill_trap",    0,0,0,0,0,TRP);
        row("ill_trap_in", 0,1,6'h00,6'h20,1,TRP);
        row("ill_rst",     1,0,0,0,0,RST4);
        row("ill_fetch2",  0,0,0,0,0,F_IDLE);
        // illegal R-type funct
        row("illr_fetch",  0,1,6'h00,6'h21,0,F_IR);   row("illr_dec", 0,0,0,0,0,DEC);
        row("illr_trap",   0,0,0,0,0,TRP);
        row("illr_rst",    1,0,0,0,0,RST4);
        row("illr_fetch2", 0,0,0,0,0,F_IDLE);
        // reset during MEM cycle 2 aborts the load, even with an ack present
        row("abort_fetch", 0,1,6'h23,6'h00,0,F_IR);   row("abort_dec",0,0,0,0,0,DEC);
        row("abort_mem1",  0,0,0,0,0,E(0,0,1,0,0,0,2'b01,0,0,3'd3));
        row("abort_rst",   1,0,0,0,1,E(0,0,0,0,0,0,2'b01,0,0,3'd3));
        row("abort_after", 0,0,0,0,0,F_IDLE);

        // Reset for two cycles, then ten idle FETCH cycles.
        drive(1,0,0,0,0); chk("rst_c1", RST0);
        drive(1,0,0,0,0); chk("rst_c2", RST0);
        for (int i = 0; i < 10; i++) begin
            drive(0,0,0,0,0); chk($sformatf("idle_%0d", i), F_IDLE);
        end

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].op, tbl[i].fn, tbl[i].ack);
            chk(tbl[i].name, tbl[i].exp);
        end

        // sw with no ack: 15 MEM cycles, then sticky TRAP until reset.
        drive(0,1,6'h2B,6'h00,0); chk("to_fetch", F_IR);
        drive(0,0,0,0,0);         chk("to_dec", DEC);
        for (int i = 0; i < 15; i++) begin
            drive(0,0,0,0,0); chk($sformatf("to_mem%0d", i + 1), E(0,0,0,1,0,0,2'b01,0,0,3'd3));
        end
        for (int i = 0; i < 4; i++) begin
            drive(0,0,0,0,(i == 1)); chk($sformatf("to_trap%0d", i), TRP);
        end
        drive(1,0,0,0,0); chk("to_rst", RST4);
        drive(0,0,0,0,0); chk("to_fetch_after", F_IDLE);

        // lw acked on the 15th MEM cycle: the ack wins over the timeout.
        drive(0,1,6'h23,6'h00,0); chk("late_fetch", F_IR);
        drive(0,0,0,0,0);         chk("late_dec", DEC);
        for (int i = 0; i < 14; i++) begin
            drive(0,0,0,0,0); chk($sformatf("late_mem%0d", i + 1), E(0,0,1,0,0,0,2'b01,0,0,3'd3));
        end
        drive(0,0,0,0,1); chk("late_mem15_ack", E(0,0,1,0,1,1,2'b01,0,0,3'd3));
        drive(0,0,0,0,0); chk("late_refetch", F_IDLE);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
